// File: rtl/seq_alu.sv
// Sequential ALU with one-operation-at-a-time handshake.
// Logic ops and add/sub finish in one cycle; shifts move one bit per cycle.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [3:0]       op;
    logic [3:0]       next_op;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] next_work;
    logic [4:0]       cnt;
    logic [4:0]       next_cnt;
    logic [WIDTH-1:0] next_result;
    logic             next_zero;
    logic             next_illegal;

    logic [WIDTH-1:0] alu_out;
    logic             legal;
    logic             is_shift;
    logic [WIDTH-1:0] step;
    logic [4:0]       shamt;

    assign shamt = b[4:0];

    // Single-cycle datapath; shift codes pass a through for the shamt == 0 case.
    always_comb begin
        alu_out  = '0;
        legal    = 1'b1;
        is_shift = 1'b0;
        unique case (ALUsel)
            OP_AND: alu_out = a & b;
            OP_OR:  alu_out = a | b;
            OP_ADD: alu_out = a + b;
            OP_XOR: alu_out = a ^ b;
            OP_SUB: alu_out = a - b;
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_out  = a;
                is_shift = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        step = work;
        unique case (op)
            OP_SLL:  step = {work[WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  step = {work[WIDTH-1], work[WIDTH-1:1]};
            default: step = work;
        endcase
    end

    always_comb begin
        next_state   = state;
        next_op      = op;
        next_work    = work;
        next_cnt     = cnt;
        next_result  = result;
        next_zero    = zero;
        next_illegal = illegal;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_op   = ALUsel;
                    next_work = a;
                    next_cnt  = shamt;
                    if (is_shift && shamt != 5'd0) begin
                        next_state = SHIFT;
                    end else begin
                        next_state   = DONE;
                        next_result  = alu_out;
                        next_zero    = (alu_out == '0);
                        next_illegal = ~legal;
                    end
                end
            end
            SHIFT: begin
                next_work = step;
                next_cnt  = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    next_state   = DONE;
                    next_result  = step;
                    next_zero    = (step == '0);
                    next_illegal = 1'b0;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            work    <= '0;
            cnt     <= '0;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            state   <= next_state;
            op      <= next_op;
            work    <= next_work;
            cnt     <= next_cnt;
            result  <= next_result;
            zero    <= next_zero;
            illegal <= next_illegal;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu.
// Expected values are hand-computed constants.
module tb_seq_alu;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_BAD = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ALUsel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;
    logic        done;

    int total;
    int passed;
    int failed;

    seq_alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ALUsel  (ALUsel),
        .a       (a),
        .b       (b),
        .result  (result),
        .zero    (zero),
        .illegal (illegal),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Issue one accepted start, then scramble the inputs.
    task automatic go(input logic [3:0] op, input logic [31:0] av,
                      input logic [31:0] bv);
        ALUsel = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ALUsel = OP_ADD;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0000_0007;
    endtask

    task automatic one_cycle(input string tag, input logic [31:0] exp_res,
                             input logic exp_zero, input logic exp_ill);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " result"}, result, exp_res);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, " illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        tick();
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " done clr"}, {31'd0, done}, 32'd0);
    endtask

    // Called right after the accept edge of an n-bit shift.
    task automatic shift_run(input string tag, input int n,
                             input logic [31:0] exp_res, input int poke);
        for (int i = 1; i <= n; i++) begin
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            check({tag, " no done"}, {31'd0, done}, 32'd0);
            if (i == poke) begin
                start  = 1'b1;
                ALUsel = OP_ADD;
                a      = 32'h0000_0100;
                b      = 32'h0000_0001;
            end
            tick();
            start = 1'b0;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy last"}, {31'd0, busy}, 32'd1);
        check({tag, " result"}, result, exp_res);
        tick();
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
        check({tag, " single done"}, {31'd0, done}, 32'd0);
        check({tag, " held"}, result, exp_res);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ALUsel = 4'b0000;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("rst result", result, 32'd0);
        check("rst zero", {31'd0, zero}, 32'd1);
        check("rst illegal", {31'd0, illegal}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        go(OP_ADD, 32'd5, 32'd7);
        check("add busy", {31'd0, busy}, 32'd1);
        one_cycle("add", 32'd12, 1'b0, 1'b0);
        check("add hold", result, 32'd12);

        go(OP_SUB, 32'd9, 32'd9);
        one_cycle("sub eq", 32'd0, 1'b1, 1'b0);
        go(OP_SUB, 32'd0, 32'd1);
        one_cycle("sub wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);
        go(OP_ADD, 32'hFFFF_FFFF, 32'd2);
        one_cycle("add wrap", 32'd1, 1'b0, 1'b0);
        go(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        one_cycle("and", 32'h0F00_0F00, 1'b0, 1'b0);
        go(OP_OR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        one_cycle("or", 32'hFF0F_FF0F, 1'b0, 1'b0);
        go(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        one_cycle("xor", 32'hF00F_F00F, 1'b0, 1'b0);

        go(OP_SRA, 32'h8000_0000, 32'd4);
        shift_run("sra4", 4, 32'hF800_0000, 0);
        go(OP_SRL, 32'h8000_0000, 32'd4);
        shift_run("srl4 poke", 4, 32'h0800_0000, 2);

        // b[4:0] == 0 even though b is nonzero
        go(OP_SLL, 32'h0000_1234, 32'h0000_0020);
        one_cycle("sll0", 32'h0000_1234, 1'b0, 1'b0);
        go(OP_SLL, 32'd1, 32'd31);
        shift_run("sll31", 31, 32'h8000_0000, 0);
        go(OP_SRL, 32'd1, 32'd1);
        shift_run("srl1 zero", 1, 32'd0, 1);
        check("srl1 zero flag", {31'd0, zero}, 32'd1);

        go(OP_BAD, 32'd3, 32'd4);
        one_cycle("illegal", 32'd0, 1'b1, 1'b1);
        go(OP_ADD, 32'd1, 32'd1);
        one_cycle("ill clr", 32'd2, 1'b0, 1'b0);

        // start held through DONE is only taken once back in IDLE
        go(OP_ADD, 32'd2, 32'd3);
        check("done cyc", {31'd0, done}, 32'd1);
        ALUsel = OP_ADD;
        a      = 32'd10;
        b      = 32'd10;
        start  = 1'b1;
        tick();
        check("start in done busy", {31'd0, busy}, 32'd0);
        check("start in done done", {31'd0, done}, 32'd0);
        check("start in done res", result, 32'd5);
        tick();
        start = 1'b0;
        check("retry done", {31'd0, done}, 32'd1);
        check("retry res", result, 32'd20);
        tick();

        go(OP_SLL, 32'd1, 32'd10);
        tick();
        tick();
        check("mid shift busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort zero", {31'd0, zero}, 32'd1);
        check("abort illegal", {31'd0, illegal}, 32'd0);
        go(OP_ADD, 32'd5, 32'd7);
        one_cycle("post rst add", 32'd12, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("quiet done", {31'd0, done}, 32'd0);
        end
        check("quiet result", result, 32'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
